tx_port_scheduler: RTL and testbench
====================================

// Module: tx_port_scheduler
// PURPOSE
//  Shares one serial transmitter between NUM_REQ router-side requesters using round-robin scheduling.
//  - Accepts 55-bit flits from each requester with a valid/ack handshake.
//  - Latches the winning flit and drives the transmitter's TX_Data/TX_Data_Valid inputs.
//  - Tracks the transmitter's TX_Ready to know when the frame is accepted and finished.
//  - Sits between the router output crossbar and the transmitter wrapper, in the Clk_S domain.
// PARAMETERS
//  NUM_REQ       4   number of requesters (2..8)
//  DATA_W        55  flit width; must match transmitter TX_Data width
//  BUSY_TIMEOUT  16  max cycles in WAIT_BUSY for TX_Ready to fall before abort (>=2)
//  GAP_CYCLES    2   idle cycles forced between end of frame and next issue (0..15)
// PORTS
//  Clk_S          in   1               clock
//  Rst            in   1               synchronous reset, active-high
//  Req_Valid      in   NUM_REQ         per-requester flit pending
//  Req_Data       in   NUM_REQ*DATA_W  flits; requester i at [i*DATA_W +: DATA_W]
//  Req_Ack        out  NUM_REQ         one-cycle pulse: requester's flit captured
//  TX_Ready       in   1               transmitter idle/ready
//  TX_Data        out  DATA_W          flit to transmitter (registered)
//  TX_Data_Valid  out  1               one-cycle issue strobe to transmitter
//  Busy           out  1               scheduler not in IDLE
//  Last_Grant     out  clog2(NUM_REQ)  index of most recent winner
//  Timeout_Err    out  1               sticky: transmitter failed to accept a frame
//  Err_Clr        in   1               clears Timeout_Err
// BEHAVIOUR
//  Reset values: Req_Ack=0, TX_Data=0, TX_Data_Valid=0, Busy=0, Last_Grant=0.
//  Reset values, continued: Timeout_Err=0, state=IDLE, RR pointer=0, counters=0.
//  Reset mid-frame aborts immediately; the transmitter is not informed.
//  Registered FSM with four states.
//  IDLE:
//  - Enabled when TX_Ready=1, gap counter=0, and |Req_Valid.
//  - Winner = first set Req_Valid at or after the RR pointer, with wrap.
//  - Capture the winner's data into TX_Data, pulse Req_Ack[winner] for one cycle.
//  - Last_Grant<=winner; RR pointer<=winner+1 (mod NUM_REQ); next state ISSUE.
//  ISSUE:
//  - TX_Data_Valid=1 for exactly this one cycle; busy counter<=0; next state WAIT_BUSY.
//  WAIT_BUSY:
//  - TX_Ready=0 -> WAIT_DONE.
//  - Otherwise busy counter++.
//  - Counter reaching BUSY_TIMEOUT-1 -> set Timeout_Err, go IDLE, load gap counter.
//  - The flit is dropped; no retry.
//  WAIT_DONE:
//  - TX_Ready=1 -> IDLE and load gap counter with GAP_CYCLES.
//  Gap counter decrements in IDLE until it reaches 0.
//  TX_Data is held stable from capture until the next capture; never changes outside IDLE.
//  Latency: Req_Valid seen in IDLE (ready, no gap) -> Req_Ack same cycle -> TX_Data_Valid next cycle.
//  Req_Ack is combinational from registered state plus Req_Valid.
//  The requester must hold Req_Valid/Req_Data until Req_Ack and drop/advance the cycle after it.
//  Req_Valid deasserted before ack: the request is withdrawn with no side effects.
//  At most one Req_Ack bit is high in any cycle. No requester waits more than NUM_REQ-1 grants.
//  Err_Clr and a timeout in the same cycle: set wins.
//  Busy = (state != IDLE).
// TESTING
//  1) Single request, transmitter model drops TX_Ready 1 cycle after valid, busy 60 cycles:
//     Req_Valid[2]=1, data 55'h2A5A5 -> Req_Ack[2] cycle N, TX_Data_Valid cycle N+1 with TX_Data=55'h2A5A5.
//     Then Busy=1 until TX_Ready returns, and next issue no earlier than GAP_CYCLES later.
//  2) All four Req_Valid held high:
//     -> grants in order 0,1,2,3,0,... with Last_Grant matching and exactly one Req_Ack per frame.
//  3) Req_Valid 1 and 3 only, RR pointer=2 -> grant 3 then 1; requester 3 withdrawn before ack -> grant 1 only.
//  4) Transmitter never drops TX_Ready:
//     -> Timeout_Err=1 after 16 WAIT_BUSY cycles, return to IDLE, and next request still granted.
//     -> Err_Clr clears Timeout_Err.
//  5) Rst asserted during WAIT_DONE -> next cycle all outputs at reset values.
//     After release, a new request is granted with RR starting at 0.
//

Source files
------------

// File: rtl/tx_port_scheduler.sv
// tx_port_scheduler: round-robin sharing of one serial transmitter among
// NUM_REQ requesters. A winner's flit is latched, strobed out for one cycle,
// then the transmitter's TX_Ready is tracked until the frame is done.
module tx_port_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_W       = 55,
  parameter int BUSY_TIMEOUT = 16,
  parameter int GAP_CYCLES   = 2
) (
  input  logic                       Clk_S,
  input  logic                       Rst,
  input  logic [NUM_REQ-1:0]         Req_Valid,
  input  logic [NUM_REQ*DATA_W-1:0]  Req_Data,
  output logic [NUM_REQ-1:0]         Req_Ack,
  input  logic                       TX_Ready,
  output logic [DATA_W-1:0]          TX_Data,
  output logic                       TX_Data_Valid,
  output logic                       Busy,
  output logic [$clog2(NUM_REQ)-1:0] Last_Grant,
  output logic                       Timeout_Err,
  input  logic                       Err_Clr
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = $clog2(BUSY_TIMEOUT);
  localparam logic [BW-1:0] BUSY_LAST = BW'(BUSY_TIMEOUT - 1);
  localparam logic [3:0]    GAP_LOAD  = 4'(GAP_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE} state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     rr_q, rr_d;
  logic [IW-1:0]     grant_q, grant_d;
  logic [BW-1:0]     busy_cnt_q, busy_cnt_d;
  logic [3:0]        gap_q, gap_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_q, err_d;

  logic [IW-1:0]     win_idx, lo_idx, hi_idx;
  logic              hi_found;
  logic [DATA_W-1:0] win_data;
  logic              issue_en;

  // Round-robin pick: lowest requester at/above the pointer, else lowest overall.
  always_comb begin
    hi_found = 1'b0;
    lo_idx   = '0;
    hi_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (Req_Valid[i]) lo_idx = IW'(i);
      if (Req_Valid[i] && (IW'(i) >= rr_q)) begin
        hi_found = 1'b1;
        hi_idx   = IW'(i);
      end
    end
    win_idx  = hi_found ? hi_idx : lo_idx;
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (IW'(i) == win_idx) win_data = Req_Data[i*DATA_W +: DATA_W];
  end

  // A grant happens in IDLE once the gap has drained and the transmitter is ready.
  always_comb begin
    issue_en = (state_q == S_IDLE) && TX_Ready && (gap_q == 4'd0) && (|Req_Valid);
    Req_Ack  = issue_en ? (NUM_REQ'(1) << win_idx) : '0;
  end

  // Next-state logic; a timeout in the same cycle as Err_Clr leaves the error set.
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    grant_d    = grant_q;
    busy_cnt_d = busy_cnt_q;
    gap_d      = gap_q;
    data_d     = data_q;
    err_d      = err_q;
    if (Err_Clr) err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (gap_q != 4'd0) begin
          gap_d = gap_q - 4'd1;
        end else if (issue_en) begin
          data_d  = win_data;
          grant_d = win_idx;
          rr_d    = (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + IW'(1);
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        busy_cnt_d = '0;
        state_d    = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (!TX_Ready) begin
          state_d = S_WAIT_DONE;
        end else if (busy_cnt_q == BUSY_LAST) begin
          // transmitter never took the frame: drop it and flag
          err_d   = 1'b1;
          gap_d   = GAP_LOAD;
          state_d = S_IDLE;
        end else begin
          busy_cnt_d = busy_cnt_q + BW'(1);
        end
      end
      S_WAIT_DONE: begin
        if (TX_Ready) begin
          gap_d   = GAP_LOAD;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge Clk_S) begin
    if (Rst) begin
      state_q    <= S_IDLE;
      rr_q       <= '0;
      grant_q    <= '0;
      busy_cnt_q <= '0;
      gap_q      <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      grant_q    <= grant_d;
      busy_cnt_q <= busy_cnt_d;
      gap_q      <= gap_d;
      data_q     <= data_d;
      err_q      <= err_d;
    end
  end

  assign TX_Data       = data_q;
  assign TX_Data_Valid = (state_q == S_ISSUE);
  assign Busy          = (state_q != S_IDLE);
  assign Last_Grant    = grant_q;
  assign Timeout_Err   = err_q;

endmodule

// File: tb/tb_tx_port_scheduler.sv
// Randomized bench for tx_port_scheduler. The reference model works per
// frame: round-robin pick by modular arithmetic, and a timeline of when the
// frame ends derived from the transmitter's drop delay and busy length.
module tb_tx_port_scheduler;
  localparam int NR = 4, DW = 55, BT = 16, GAP = 2;

  logic          Clk_S = 1'b0;
  logic          Rst = 1'b1;
  logic [NR-1:0] Req_Valid = '0;
  logic [NR*DW-1:0] Req_Data = '0;
  logic [NR-1:0] Req_Ack;
  logic          TX_Ready = 1'b1;
  logic [DW-1:0] TX_Data;
  logic          TX_Data_Valid;
  logic          Busy;
  logic [1:0]    Last_Grant;
  logic          Timeout_Err;
  logic          Err_Clr = 1'b0;

  tx_port_scheduler #(.NUM_REQ(NR), .DATA_W(DW), .BUSY_TIMEOUT(BT), .GAP_CYCLES(GAP)) dut (
    .Clk_S(Clk_S), .Rst(Rst), .Req_Valid(Req_Valid), .Req_Data(Req_Data), .Req_Ack(Req_Ack),
    .TX_Ready(TX_Ready), .TX_Data(TX_Data), .TX_Data_Valid(TX_Data_Valid), .Busy(Busy),
    .Last_Grant(Last_Grant), .Timeout_Err(Timeout_Err), .Err_Clr(Err_Clr)
  );

  always #5 Clk_S = ~Clk_S;

  int nchk = 0, nerr = 0;
  // model state
  int ptr = 0, lg = 0, gap_left = 0;
  bit err = 1'b0;
  logic [DW-1:0] last_d = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk_S);
    #1;
  endtask

  function automatic int rr_pick(input logic [NR-1:0] m, input int p);
    for (int k = 0; k < NR; k++)
      if (((m >> ((p + k) % NR)) & 1) != 0) return (p + k) % NR;
    return 0;
  endfunction

  task automatic chk_reset_vals();
    chk("rst_ack", Req_Ack, 0);
    chk("rst_txd", TX_Data, 0);
    chk("rst_dv", TX_Data_Valid, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_lg", Last_Grant, 0);
    chk("rst_err", Timeout_Err, 0);
  endtask

  // One frame starting at the first IDLE cycle. j: cycles after the strobe
  // until TX_Ready drops; L: cycles it stays low; tmo: never drops.
  task automatic run_frame(input logic [NR-1:0] mask, input bit tmo, input int j, input int L,
                           input int rst_at, input logic [DW-1:0] d2);
    logic [DW-1:0] d [NR];
    int w, span;
    bit ev;
    // forced gap: requests shown here must be ignored, then withdrawn
    for (int g = 0; g < gap_left; g++) begin
      Req_Valid = NR'($urandom);
      TX_Ready  = 1'b1;
      Err_Clr   = ($urandom_range(0, 7) == 0);
      #1;
      chk("gap_ack", Req_Ack, 0);
      chk("gap_busy", Busy, 0);
      chk("gap_txd", TX_Data, last_d);
      chk("gap_err", Timeout_Err, err);
      if (Err_Clr) err = 1'b0;
      tick();
    end
    // grant cycle
    for (int i = 0; i < NR; i++) d[i] = DW'({$urandom, $urandom});
    if (d2 != '0) d[2] = d2;
    for (int i = 0; i < NR; i++) Req_Data[i*DW +: DW] = d[i];
    Req_Valid = mask;
    TX_Ready  = 1'b1;
    Err_Clr   = ($urandom_range(0, 7) == 0);
    w = rr_pick(mask, ptr);
    #1;
    chk("ack", Req_Ack, 64'(1) << w);
    chk("busy0", Busy, 0);
    chk("lg0", Last_Grant, lg);
    chk("err0", Timeout_Err, err);
    if (Err_Clr) err = 1'b0;
    ptr = (w + 1) % NR;
    lg = w;
    last_d = d[w];
    span = tmo ? (BT + 2) : (2 + j + L);
    tick();
    for (int t = 1; t < span; t++) begin
      Req_Valid = NR'($urandom);
      Req_Data  = {NR{DW'({$urandom, $urandom})}};
      TX_Ready  = tmo ? 1'b1 : !(t >= 1 + j && t <= j + L);
      ev = tmo && (t == BT + 1);
      Err_Clr   = ev ? 1'b1 : ($urandom_range(0, 7) == 0);
      if (t == rst_at) begin
        Rst = 1'b1;
        Req_Valid = '0;
        TX_Ready = 1'b1;
        tick();
        chk_reset_vals();
        Rst = 1'b0;
        ptr = 0; lg = 0; err = 1'b0; gap_left = 0; last_d = '0;
        return;
      end
      #1;
      chk("ack_busy", Req_Ack, 0);
      chk("dv", TX_Data_Valid, (t == 1));
      chk("busy", Busy, 1);
      chk("txd", TX_Data, last_d);
      chk("lg", Last_Grant, lg);
      chk("err", Timeout_Err, err);
      if (ev) err = 1'b1;
      else if (Err_Clr) err = 1'b0;
      tick();
    end
    gap_left = GAP;
  endtask

  initial begin
    Rst = 1'b1;
    tick();
    tick();
    chk_reset_vals();
    Rst = 1'b0;
    // single request on port 2, long busy period
    run_frame(4'b0100, 1'b0, 1, 60, -1, 55'h2A5A5);
    // all requesters held: round-robin rotation
    for (int n = 0; n < 5; n++) run_frame(4'b1111, 1'b0, $urandom_range(1, 4), $urandom_range(1, 4), -1, '0);
    // move pointer to 2, then 1 and 3 pending -> 3 then 1
    run_frame(4'b0010, 1'b0, 1, 2, -1, '0);
    run_frame(4'b1010, 1'b0, 2, 1, -1, '0);
    run_frame(4'b1010, 1'b0, 1, 1, -1, '0);
    // pointer back at 2 with only 1 present (3 withdrawn in the gap)
    run_frame(4'b0010, 1'b0, 3, 2, -1, '0);
    // transmitter never drops ready: timeout, then clear explicitly
    run_frame(4'b0100, 1'b1, 0, 0, -1, '0);
    Req_Valid = '0; Err_Clr = 1'b1; TX_Ready = 1'b1;
    #1;
    chk("tmo_set", Timeout_Err, err);
    err = 1'b0;
    tick();
    gap_left--;
    Err_Clr = 1'b0;
    run_frame(4'b1001, 1'b0, 2, 3, -1, '0);
    // reset while in WAIT_DONE
    run_frame(4'b1111, 1'b0, 1, 30, 5, '0);
    run_frame(4'b1111, 1'b0, 1, 2, -1, '0);
    // random traffic
    for (int n = 0; n < 40; n++)
      run_frame(NR'($urandom_range(1, 15)), ($urandom_range(0, 4) == 0),
                $urandom_range(1, BT), $urandom_range(1, 8), -1, '0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
